// File: rtl/histogram_equalizer_master_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_equalizer_master_fsm_if
//  Brief    : Control and status bundle between the histogram equalizer core
//             and its master sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface histogram_equalizer_master_fsm_if;
    logic        frame_start;
    logic [15:0] histogram_input_mem_raddr0;
    logic [15:0] histogram_input_mem_raddr1;
    logic        histogram_computation_done;
    logic        cdf_computation_done;
    logic        divider_computation_done;
    logic        start_histogram;
    logic        start_cdf;
    logic        start_divider;
    logic        input_mem_read_finished;
    logic        busy;
    logic        frame_done;
    logic [2:0]  phase;
    logic        watchdog_error;

    modport master (
        input  frame_start,
        input  histogram_input_mem_raddr0,
        input  histogram_input_mem_raddr1,
        input  histogram_computation_done,
        input  cdf_computation_done,
        input  divider_computation_done,
        output start_histogram,
        output start_cdf,
        output start_divider,
        output input_mem_read_finished,
        output busy,
        output frame_done,
        output phase,
        output watchdog_error
    );

    modport slave (
        output frame_start,
        output histogram_input_mem_raddr0,
        output histogram_input_mem_raddr1,
        output histogram_computation_done,
        output cdf_computation_done,
        output divider_computation_done,
        input  start_histogram,
        input  start_cdf,
        input  start_divider,
        input  input_mem_read_finished,
        input  busy,
        input  frame_done,
        input  phase,
        input  watchdog_error
    );
endinterface
`default_nettype wire

// File: rtl/histogram_equalizer_master_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_equalizer_master_fsm
//  Brief    : Sequences histogram -> CDF -> divider phases for one frame.
//             Optional phase watchdog enabled by HIST_EQ_MASTER_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module histogram_equalizer_master_fsm #(
    parameter logic [15:0] LAST_INPUT_ADDR = 16'd4095,
    parameter logic [23:0] WATCHDOG_CYCLES = 24'd200000
) (
    input  wire logic                           clk_i,
    input  wire logic                           rst_i,
    histogram_equalizer_master_fsm_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_HIST_START = 3'd1,
        S_HIST_RUN   = 3'd2,
        S_CDF_START  = 3'd3,
        S_CDF_RUN    = 3'd4,
        S_DIV_START  = 3'd5,
        S_DIV_RUN    = 3'd6,
        S_DONE       = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic       rd_fin_q, rd_fin_d;
    logic       start_hist_q, start_hist_d;
    logic       start_cdf_q, start_cdf_d;
    logic       start_div_q, start_div_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic [2:0] phase_q, phase_d;

    logic addr_hit;
    logic phase_done;
    logic timeout;

    assign addr_hit = (bus.histogram_input_mem_raddr0 >= LAST_INPUT_ADDR) ||
                      (bus.histogram_input_mem_raddr1 >= LAST_INPUT_ADDR);

    assign phase_done = ((state_q == S_HIST_RUN) && bus.histogram_computation_done) ||
                        ((state_q == S_CDF_RUN)  && bus.cdf_computation_done)       ||
                        ((state_q == S_DIV_RUN)  && bus.divider_computation_done);

    // Phase completion is tested before timeout so a same-cycle done wins.
    always_comb begin
        state_d  = state_q;
        rd_fin_d = rd_fin_q;
        case (state_q)
            S_IDLE: begin
                rd_fin_d = 1'b0;
                if (bus.frame_start) begin
                    state_d = S_HIST_START;
                end
            end
            S_HIST_START: state_d = S_HIST_RUN;
            S_HIST_RUN: begin
                if (bus.histogram_computation_done) begin
                    state_d  = S_CDF_START;
                    rd_fin_d = 1'b0;
                end else if (timeout) begin
                    state_d  = S_IDLE;
                    rd_fin_d = 1'b0;
                end else if (addr_hit) begin
                    rd_fin_d = 1'b1;
                end
            end
            S_CDF_START: state_d = S_CDF_RUN;
            S_CDF_RUN: begin
                if (bus.cdf_computation_done) begin
                    state_d = S_DIV_START;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DIV_START: state_d = S_DIV_RUN;
            S_DIV_RUN: begin
                if (bus.divider_computation_done) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        start_hist_d = (state_q == S_HIST_START);
        start_cdf_d  = (state_q == S_CDF_START);
        start_div_d  = (state_q == S_DIV_START);
        busy_d       = (state_q != S_IDLE);
        frame_done_d = (state_q == S_DONE);
        phase_d      = state_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            rd_fin_q     <= 1'b0;
            start_hist_q <= 1'b0;
            start_cdf_q  <= 1'b0;
            start_div_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            phase_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            rd_fin_q     <= rd_fin_d;
            start_hist_q <= start_hist_d;
            start_cdf_q  <= start_cdf_d;
            start_div_q  <= start_div_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            phase_q      <= phase_d;
        end
    end

    assign bus.start_histogram         = start_hist_q;
    assign bus.start_cdf               = start_cdf_q;
    assign bus.start_divider           = start_div_q;
    assign bus.input_mem_read_finished = rd_fin_q;
    assign bus.busy                    = busy_q;
    assign bus.frame_done              = frame_done_q;
    assign bus.phase                   = phase_q;

`ifdef HIST_EQ_MASTER_WATCHDOG_EN
    logic [23:0] wd_cnt_q, wd_cnt_d;
    logic        wd_err_q, wd_err_d;
    logic        in_run;

    assign in_run  = (state_q == S_HIST_RUN) || (state_q == S_CDF_RUN) ||
                     (state_q == S_DIV_RUN);
    // Fires on the run cycle whose increment would bring the count to the limit.
    assign timeout = in_run && (wd_cnt_q >= (WATCHDOG_CYCLES - 24'd1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_err_d = wd_err_q;
        case (state_q)
            S_HIST_START, S_CDF_START, S_DIV_START: wd_cnt_d = 24'd0;
            S_HIST_RUN, S_CDF_RUN, S_DIV_RUN:       wd_cnt_d = wd_cnt_q + 24'd1;
            default:                                wd_cnt_d = wd_cnt_q;
        endcase
        if ((state_q == S_IDLE) && bus.frame_start) begin
            wd_err_d = 1'b0;
        end else if (timeout && !phase_done) begin
            wd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= 24'd0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign bus.watchdog_error = wd_err_q;
`else
    logic unused_wdog;

    assign timeout            = 1'b0;
    assign unused_wdog        = (^WATCHDOG_CYCLES) ^ phase_done;
    assign bus.watchdog_error = 1'b0;
`endif

endmodule
`default_nettype wire
